// File: rtl/wdt_bus_ctrl.sv
// Byte-wide register front end for the 16-bit watchdog: key-gated writes,
// atomic 16-bit counter reloads and tear-free 16-bit counter reads.
module wdt_bus_ctrl #(
    parameter logic [7:0]  KEY1   = 8'h55,
    parameter logic [7:0]  KEY2   = 8'hAA,
    parameter int unsigned WINDOW = 16
) (
    input  logic        clk,
    input  logic        power_on_reset,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  rdata,
    input  logic [15:0] wd_counter_in,
    input  logic [7:0]  wd_config_in,
    output logic [15:0] wd_counter_out,
    output logic [1:0]  wd_counter_write,
    output logic [7:0]  wd_config_out,
    output logic        wd_config_write,
    output logic        violation
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1_OK  = 2'd1,
        UNLOCKED = 2'd2
    } state_t;

    localparam logic [2:0] A_CNT_LO = 3'd0;
    localparam logic [2:0] A_CNT_HI = 3'd1;
    localparam logic [2:0] A_CONFIG = 3'd2;
    localparam logic [2:0] A_KEY    = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [7:0] WIN_LOAD = 8'(WINDOW);

    state_t      state_q, state_d;
    logic [7:0]  win_q, win_d;
    logic [7:0]  lo_stage_q, lo_stage_d;
    logic [7:0]  hi_snap_q, hi_snap_d;
    logic        sticky_q, sticky_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] cnt_out_q, cnt_out_d;
    logic [1:0]  cnt_wr_q, cnt_wr_d;
    logic [7:0]  cfg_out_q, cfg_out_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic        viol_q, viol_d;

    logic wr_key;
    logic wr_prot;
    logic accept;

    assign wr_key  = wr && (addr == A_KEY);
    assign wr_prot = wr && ((addr == A_CNT_HI) || (addr == A_CONFIG));

    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            state_q    <= LOCKED;
            win_q      <= 8'd0;
            lo_stage_q <= 8'd0;
            hi_snap_q  <= 8'd0;
            sticky_q   <= 1'b0;
            rdata_q    <= 8'd0;
            cnt_out_q  <= 16'd0;
            cnt_wr_q   <= 2'b00;
            cfg_out_q  <= 8'd0;
            cfg_wr_q   <= 1'b0;
            viol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            lo_stage_q <= lo_stage_d;
            hi_snap_q  <= hi_snap_d;
            sticky_q   <= sticky_d;
            rdata_q    <= rdata_d;
            cnt_out_q  <= cnt_out_d;
            cnt_wr_q   <= cnt_wr_d;
            cfg_out_q  <= cfg_out_d;
            cfg_wr_q   <= cfg_wr_d;
            viol_q     <= viol_d;
        end
    end

    // Unlock FSM; the window timeout is applied first so that key and
    // protected-write decisions in the same cycle take precedence over it.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        viol_d  = 1'b0;
        accept  = 1'b0;

        if (state_q != LOCKED) begin
            win_d = win_q - 8'd1;
            if (win_q <= 8'd1) begin
                state_d = LOCKED;
            end
        end

        case (state_q)
            LOCKED: begin
                if (wr_key) begin
                    if (wdata == KEY1) begin
                        state_d = KEY1_OK;
                        win_d   = WIN_LOAD;
                    end else begin
                        viol_d = 1'b1;
                    end
                end else if (wr_prot) begin
                    viol_d = 1'b1;
                end
            end
            KEY1_OK: begin
                if (wr_key) begin
                    if (wdata == KEY2) begin
                        state_d = UNLOCKED;
                        win_d   = WIN_LOAD;
                    end else begin
                        state_d = LOCKED;
                        viol_d  = 1'b1;
                    end
                end else if (wr_prot) begin
                    state_d = LOCKED;
                    viol_d  = 1'b1;
                end
            end
            UNLOCKED: begin
                if (wr_key) begin
                    state_d = LOCKED;
                end else if (wr_prot) begin
                    state_d = LOCKED;
                    accept  = 1'b1;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    // Register file: staging, snapshots, watchdog strobes and read mux.
    always_comb begin
        lo_stage_d = lo_stage_q;
        hi_snap_d  = hi_snap_q;
        sticky_d   = sticky_q;
        rdata_d    = rdata_q;
        cnt_out_d  = cnt_out_q;
        cnt_wr_d   = 2'b00;
        cfg_out_d  = cfg_out_q;
        cfg_wr_d   = 1'b0;

        if (wr && (addr == A_CNT_LO)) begin
            lo_stage_d = wdata;
        end
        if (wr && (addr == A_STATUS) && wdata[2]) begin
            sticky_d = 1'b0;
        end
        if (viol_d) begin
            sticky_d = 1'b1;
        end
        if (accept && (addr == A_CNT_HI)) begin
            cnt_out_d = {wdata, lo_stage_q};
            cnt_wr_d  = 2'b11;
        end
        if (accept && (addr == A_CONFIG)) begin
            cfg_out_d = wdata;
            cfg_wr_d  = 1'b1;
        end

        if (rd) begin
            case (addr)
                A_CNT_LO: begin
                    rdata_d   = wd_counter_in[7:0];
                    hi_snap_d = wd_counter_in[15:8];
                end
                A_CNT_HI: rdata_d = hi_snap_q;
                A_CONFIG: rdata_d = wd_config_in;
                A_STATUS: rdata_d = {5'b00000, sticky_q, state_q};
                default:  rdata_d = 8'd0;
            endcase
        end
    end

    assign rdata            = rdata_q;
    assign wd_counter_out   = cnt_out_q;
    assign wd_counter_write = cnt_wr_q;
    assign wd_config_out    = cfg_out_q;
    assign wd_config_write  = cfg_wr_q;
    assign violation        = viol_q;

endmodule

// File: tb/tb_wdt_bus_ctrl.sv
// Bench for wdt_bus_ctrl: directed scenarios with constant expectations, then
// randomized traffic against a deadline-based lock model.
module tb_wdt_bus_ctrl;

    localparam int         WINDOW = 16;
    localparam logic [7:0] KEY1   = 8'h55;
    localparam logic [7:0] KEY2   = 8'hAA;
    localparam logic [2:0] A_CNT_LO = 3'd0;
    localparam logic [2:0] A_CNT_HI = 3'd1;
    localparam logic [2:0] A_CONFIG = 3'd2;
    localparam logic [2:0] A_KEY    = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic        clk = 1'b0;
    logic        power_on_reset = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  wdata = 8'd0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  rdata;
    logic [15:0] wd_counter_in = 16'hBEEF;
    logic [7:0]  wd_config_in = 8'h3C;
    logic [15:0] wd_counter_out;
    logic [1:0]  wd_counter_write;
    logic [7:0]  wd_config_out;
    logic        wd_config_write;
    logic        violation;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: lock level plus the last cycle number the unlock holds.
    logic [1:0]  m_level;
    int          m_last;
    logic [7:0]  m_lo, m_snap;
    logic        m_sticky;
    logic [7:0]  exp_rdata, exp_cfg_out;
    logic [15:0] exp_cnt_out;
    logic [1:0]  exp_cnt_wr;
    logic        exp_cfg_wr, exp_viol;

    wdt_bus_ctrl #(.KEY1(KEY1), .KEY2(KEY2), .WINDOW(WINDOW)) dut (
        .clk(clk),
        .power_on_reset(power_on_reset),
        .addr(addr),
        .wdata(wdata),
        .wr(wr),
        .rd(rd),
        .rdata(rdata),
        .wd_counter_in(wd_counter_in),
        .wd_config_in(wd_config_in),
        .wd_counter_out(wd_counter_out),
        .wd_counter_write(wd_counter_write),
        .wd_config_out(wd_config_out),
        .wd_config_write(wd_config_write),
        .violation(violation)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_level = 2'd0; m_last = 0; m_lo = 8'd0; m_snap = 8'd0; m_sticky = 1'b0;
        exp_rdata = 8'd0; exp_cnt_out = 16'd0; exp_cnt_wr = 2'b00;
        exp_cfg_out = 8'd0; exp_cfg_wr = 1'b0; exp_viol = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic r,
                                       input logic [2:0] a, input logic [7:0] d);
        logic bad;
        bad = 1'b0;
        exp_cnt_wr = 2'b00; exp_cfg_wr = 1'b0; exp_viol = 1'b0;
        if (m_level != 2'd0 && cyc > m_last) m_level = 2'd0;
        if (r) begin
            case (a)
                A_CNT_LO: begin exp_rdata = wd_counter_in[7:0]; m_snap = wd_counter_in[15:8]; end
                A_CNT_HI: exp_rdata = m_snap;
                A_CONFIG: exp_rdata = wd_config_in;
                A_STATUS: exp_rdata = {5'b00000, m_sticky, m_level};
                default:  exp_rdata = 8'd0;
            endcase
        end
        if (w) begin
            if (a == A_CNT_LO) m_lo = d;
            if (a == A_STATUS && d[2]) m_sticky = 1'b0;
            if (a == A_KEY) begin
                if (m_level == 2'd0) begin
                    if (d == KEY1) begin m_level = 2'd1; m_last = cyc + WINDOW; end
                    else bad = 1'b1;
                end else if (m_level == 2'd1) begin
                    if (d == KEY2) begin m_level = 2'd2; m_last = cyc + WINDOW; end
                    else begin m_level = 2'd0; bad = 1'b1; end
                end else begin
                    m_level = 2'd0;
                end
            end
            if (a == A_CNT_HI || a == A_CONFIG) begin
                if (m_level == 2'd2) begin
                    if (a == A_CNT_HI) begin exp_cnt_out = {d, m_lo}; exp_cnt_wr = 2'b11; end
                    else begin exp_cfg_out = d; exp_cfg_wr = 1'b1; end
                end else begin
                    bad = 1'b1;
                end
                m_level = 2'd0;
            end
        end
        if (bad) begin exp_viol = 1'b1; m_sticky = 1'b1; end
    endfunction

    // One bus cycle; returns #1 after the edge with outputs for this access.
    task automatic cycle(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
        wr = w; rd = r; addr = a; wdata = d;
        cyc++;
        model_step(w, r, a, d);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic hold_reset(input int n);
        power_on_reset = 1'b1;
        wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 8'd0;
        model_reset();
        #1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        hold_reset(3);
        tests++; if (rdata !== 8'd0) begin fails++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        tests++; if (wd_counter_out !== 16'd0) begin fails++; $display("FAIL rst_cnt_out: got %h want 0000", wd_counter_out); end
        tests++; if (wd_counter_write !== 2'b00) begin fails++; $display("FAIL rst_cnt_wr: got %b want 00", wd_counter_write); end
        tests++; if (wd_config_out !== 8'd0) begin fails++; $display("FAIL rst_cfg_out: got %h want 00", wd_config_out); end
        tests++; if (wd_config_write !== 1'b0) begin fails++; $display("FAIL rst_cfg_wr: got %b want 0", wd_config_write); end
        tests++; if (violation !== 1'b0) begin fails++; $display("FAIL rst_viol: got %b want 0", violation); end
        power_on_reset = 1'b0;
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_status: got %h want 00", rdata); end
    endtask

    task automatic test_locked_write();
        cycle(1'b1, 1'b0, A_CNT_HI, 8'h12);
        tests++; if (wd_counter_write !== 2'b00) begin fails++; $display("FAIL locked_cnt_wr: got %b want 00", wd_counter_write); end
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL locked_viol: got %b want 1", violation); end
        cycle(1'b0, 1'b0, 3'd0, 8'd0);
        tests++; if (violation !== 1'b0) begin fails++; $display("FAIL locked_viol_len: got %b want 0", violation); end
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h04) begin fails++; $display("FAIL locked_status: got %h want 04", rdata); end
    endtask

    task automatic test_unlock_counter();
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        cycle(1'b1, 1'b0, A_CNT_LO, 8'h34);
        tests++; if (wd_counter_write !== 2'b00) begin fails++; $display("FAIL cntlo_no_strobe: got %b want 00", wd_counter_write); end
        cycle(1'b1, 1'b0, A_CNT_HI, 8'h12);
        tests++; if (wd_counter_out !== 16'h1234) begin fails++; $display("FAIL reload_value: got %h want 1234", wd_counter_out); end
        tests++; if (wd_counter_write !== 2'b11) begin fails++; $display("FAIL reload_strobe: got %b want 11", wd_counter_write); end
        tests++; if (violation !== 1'b0) begin fails++; $display("FAIL reload_viol: got %b want 0", violation); end
        cycle(1'b0, 1'b0, 3'd0, 8'd0);
        tests++; if (wd_counter_write !== 2'b00) begin fails++; $display("FAIL reload_strobe_len: got %b want 00", wd_counter_write); end
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h04) begin fails++; $display("FAIL relock_status: got %h want 04", rdata); end
    endtask

    task automatic test_window();
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        repeat (WINDOW) cycle(1'b0, 1'b0, 3'd0, 8'd0);
        cycle(1'b1, 1'b0, A_CONFIG, 8'h01);
        tests++; if (wd_config_write !== 1'b0) begin fails++; $display("FAIL expired_cfg_wr: got %b want 0", wd_config_write); end
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL expired_viol: got %b want 1", violation); end
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        repeat (WINDOW - 1) cycle(1'b0, 1'b0, 3'd0, 8'd0);
        cycle(1'b1, 1'b0, A_CONFIG, 8'h01);
        tests++; if (wd_config_write !== 1'b1) begin fails++; $display("FAIL lastcycle_cfg_wr: got %b want 1", wd_config_write); end
        tests++; if (wd_config_out !== 8'h01) begin fails++; $display("FAIL lastcycle_cfg_out: got %h want 01", wd_config_out); end
        tests++; if (violation !== 1'b0) begin fails++; $display("FAIL lastcycle_viol: got %b want 0", violation); end
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        repeat (WINDOW) cycle(1'b0, 1'b0, 3'd0, 8'd0);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL key1_expired_viol: got %b want 1", violation); end
    endtask

    task automatic test_bad_key();
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'h5A);
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL badkey_viol: got %b want 1", violation); end
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h04) begin fails++; $display("FAIL badkey_status: got %h want 04", rdata); end
        cycle(1'b1, 1'b0, A_STATUS, 8'h04);
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL sticky_clear: got %h want 00", rdata); end
    endtask

    task automatic test_snapshot();
        wd_counter_in = 16'h00FF;
        cycle(1'b0, 1'b1, A_CNT_LO, 8'd0);
        tests++; if (rdata !== 8'hFF) begin fails++; $display("FAIL snap_lo: got %h want FF", rdata); end
        wd_counter_in = 16'h0100;
        cycle(1'b0, 1'b0, 3'd0, 8'd0);
        tests++; if (rdata !== 8'hFF) begin fails++; $display("FAIL rdata_hold: got %h want FF", rdata); end
        cycle(1'b0, 1'b1, A_CNT_HI, 8'd0);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL snap_hi: got %h want 00", rdata); end
        wd_config_in = 8'hA7;
        cycle(1'b0, 1'b1, A_CONFIG, 8'd0);
        tests++; if (rdata !== 8'hA7) begin fails++; $display("FAIL cfg_read: got %h want A7", rdata); end
    endtask

    task automatic test_reset_midseq();
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        cycle(1'b1, 1'b0, A_CNT_LO, 8'h77);
        cycle(1'b1, 1'b0, A_CNT_HI, 8'h12);
        tests++; if (wd_counter_out !== 16'h1277) begin fails++; $display("FAIL pre_rst_reload: got %h want 1277", wd_counter_out); end
        hold_reset(2);
        tests++; if (wd_counter_write !== 2'b00) begin fails++; $display("FAIL midrst_cnt_wr: got %b want 00", wd_counter_write); end
        tests++; if (wd_counter_out !== 16'd0) begin fails++; $display("FAIL midrst_cnt_out: got %h want 0000", wd_counter_out); end
        power_on_reset = 1'b0;
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        hold_reset(2);
        tests++; if (rdata !== 8'd0 || wd_config_out !== 8'd0 || violation !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: got rdata=%h cfg=%h viol=%b want 00/00/0", rdata, wd_config_out, violation);
        end
        power_on_reset = 1'b0;
        cycle(1'b1, 1'b0, A_CONFIG, 8'h01);
        tests++; if (wd_config_write !== 1'b0) begin fails++; $display("FAIL postrst_cfg_wr: got %b want 0", wd_config_write); end
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL postrst_viol: got %b want 1", violation); end
        cycle(1'b1, 1'b0, A_KEY, 8'h55);
        cycle(1'b1, 1'b0, A_KEY, 8'hAA);
        cycle(1'b1, 1'b0, A_CNT_HI, 8'h56);
        tests++; if (wd_counter_out !== 16'h5600) begin fails++; $display("FAIL stage_lost: got %h want 5600", wd_counter_out); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b1, A_STATUS, 8'h04);
        tests++; if (rdata !== 8'h04) begin fails++; $display("FAIL wr_rd_prewrite: got %h want 04", rdata); end
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL wr_rd_after: got %h want 00", rdata); end
        cycle(1'b1, 1'b1, A_KEY, 8'h55);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL key_read_zero: got %h want 00", rdata); end
        cycle(1'b0, 1'b1, A_STATUS, 8'd0);
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL key1_status: got %h want 01", rdata); end
        cycle(1'b1, 1'b0, 3'd6, 8'hFF);
        tests++; if (violation !== 1'b0) begin fails++; $display("FAIL unmapped_wr_viol: got %b want 0", violation); end
        cycle(1'b1, 1'b0, A_KEY, 8'h00);
        tests++; if (violation !== 1'b1) begin fails++; $display("FAIL key1_bad_viol: got %b want 1", violation); end
    endtask

    task automatic test_random();
        int gap;
        logic w, r;
        logic [2:0] a;
        logic [7:0] d;
        gap = 0;
        for (int i = 0; i < 800; i++) begin
            wd_counter_in = 16'($urandom);
            wd_config_in  = 8'($urandom);
            a = 3'($urandom);
            d = 8'($urandom);
            if (gap > 0) begin
                gap--; w = 1'b0; r = 1'b0;
            end else begin
                if ($urandom_range(0, 24) == 0) gap = $urandom_range(WINDOW - 2, WINDOW + 1);
                w = ($urandom_range(0, 9) < 6);
                r = ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 2) == 0) a = A_KEY;
                if (a == A_KEY) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: d = KEY1;
                        5, 6, 7, 8:    d = KEY2;
                        default:       d = 8'($urandom);
                    endcase
                end
            end
            cycle(w, r, a, d);
            tests++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rand_rdata cyc=%0d: got %h want %h", cyc, rdata, exp_rdata); end
            tests++; if (wd_counter_out !== exp_cnt_out) begin fails++; $display("FAIL rand_cnt_out cyc=%0d: got %h want %h", cyc, wd_counter_out, exp_cnt_out); end
            tests++; if (wd_counter_write !== exp_cnt_wr) begin fails++; $display("FAIL rand_cnt_wr cyc=%0d: got %b want %b", cyc, wd_counter_write, exp_cnt_wr); end
            tests++; if (wd_config_out !== exp_cfg_out) begin fails++; $display("FAIL rand_cfg_out cyc=%0d: got %h want %h", cyc, wd_config_out, exp_cfg_out); end
            tests++; if (wd_config_write !== exp_cfg_wr) begin fails++; $display("FAIL rand_cfg_wr cyc=%0d: got %b want %b", cyc, wd_config_write, exp_cfg_wr); end
            tests++; if (violation !== exp_viol) begin fails++; $display("FAIL rand_viol cyc=%0d: got %b want %b", cyc, violation, exp_viol); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_locked_write();
        test_unlock_counter();
        test_window();
        test_bad_key();
        test_snapshot();
        test_reset_midseq();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
